// File: rtl/text_cmd_sequencer.sv
// Command front end for the 8x8 text area: decodes 32-bit commands, forwards config
// strobes, owns the text cursor and sequences all port-A cell-RAM traffic.
module text_cmd_sequencer #(
   parameter int unsigned NUM_COLS   = 84,
   parameter int unsigned NUM_ROWS   = 64,
   parameter int unsigned FILL_CNT_W = 12
) (
   input  logic        i_cmd_clk,
   input  logic        i_rst_n,
   input  logic        i_cmd_valid,
   input  logic [31:0] i_cmd_data,
   output logic        o_cmd_ready,
   output logic        o_cfg_valid,
   output logic [31:0] o_cfg_data,
   output logic [12:0] o_ram_addr,
   output logic        o_ram_we,
   output logic [15:0] o_ram_wdata,
   input  logic [15:0] i_ram_rdata,
   output logic        o_rd_valid,
   output logic [15:0] o_rd_data,
   output logic [5:0]  o_cursor_row,
   output logic [6:0]  o_cursor_col
);

   localparam int unsigned COL_W = 7;
   localparam int unsigned ROW_W = 6;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CFG  = 3'd1;
   localparam logic [2:0] S_WRF  = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_MOD  = 3'd4;
   localparam logic [2:0] S_FILL = 3'd5;
   localparam logic [2:0] S_RBK  = 3'd6;

   logic [2:0]            r_state, w_state_nxt;
   logic                  r_ready, w_ready_nxt;
   logic [3:0]            r_op, w_op_nxt;
   logic [7:0]            r_fld, w_fld_nxt;
   logic [FILL_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [ROW_W-1:0]      r_row, w_row_nxt, w_adv_row;
   logic [COL_W-1:0]      r_col, w_col_nxt, w_adv_col, w_set_col;
   logic [12:0]           r_addr, w_addr_nxt;
   logic                  r_we, w_we_nxt;
   logic [15:0]           r_wdata, w_wdata_nxt, w_merge;
   logic                  r_cfg_valid, w_cfg_valid_nxt;
   logic [31:0]           r_cfg_data, w_cfg_data_nxt;
   logic                  r_rd_valid, w_rd_valid_nxt;
   logic [15:0]           r_rd_data, w_rd_data_nxt;

   // Cursor advance: column first, then row, wrapping the whole screen to (0,0)
   always_comb begin
      w_adv_col = r_col + COL_W'(1);
      w_adv_row = r_row;
      if (r_col == COL_W'(NUM_COLS - 1)) begin
         w_adv_col = '0;
         w_adv_row = (r_row == ROW_W'(NUM_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      end
   end

   assign w_set_col = (i_cmd_data[22:16] >= COL_W'(NUM_COLS)) ? COL_W'(NUM_COLS - 1)
                                                             : i_cmd_data[22:16];

   // Read data only arrives in the MOD cycle, so the merged word bypasses the register
   always_comb begin
      case (r_op)
         4'h9:    w_merge = {r_fld[3:0], i_ram_rdata[11:0]};
         4'hA:    w_merge = {i_ram_rdata[15:12], r_fld[3:0], i_ram_rdata[7:0]};
         default: w_merge = {i_ram_rdata[15:8], r_fld};
      endcase
   end

   always_ff @(posedge i_cmd_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_op        <= '0;
         r_fld       <= '0;
         r_cnt       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_cfg_valid <= 1'b0;
         r_cfg_data  <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ready     <= w_ready_nxt;
         r_op        <= w_op_nxt;
         r_fld       <= w_fld_nxt;
         r_cnt       <= w_cnt_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_addr      <= w_addr_nxt;
         r_we        <= w_we_nxt;
         r_wdata     <= w_wdata_nxt;
         r_cfg_valid <= w_cfg_valid_nxt;
         r_cfg_data  <= w_cfg_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_rd_data   <= w_rd_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_op_nxt        = r_op;
      w_fld_nxt       = r_fld;
      w_cnt_nxt       = r_cnt;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_addr_nxt      = r_addr;
      w_we_nxt        = 1'b0;
      w_wdata_nxt     = r_wdata;
      w_cfg_valid_nxt = 1'b0;
      w_cfg_data_nxt  = r_cfg_data;
      w_rd_valid_nxt  = 1'b0;
      w_rd_data_nxt   = r_rd_data;
      case (r_state)
         S_IDLE: begin
            if (i_cmd_valid) begin
               w_op_nxt  = i_cmd_data[31:28];
               w_fld_nxt = i_cmd_data[7:0];
               case (i_cmd_data[31:28])
                  4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                     w_state_nxt     = S_CFG;
                     w_cfg_valid_nxt = 1'b1;
                     w_cfg_data_nxt  = i_cmd_data;
                  end
                  4'h7: begin
                     w_row_nxt = i_cmd_data[5:0];
                     w_col_nxt = w_set_col;
                  end
                  4'h8: begin
                     w_state_nxt = S_WRF;
                     w_we_nxt    = 1'b1;
                     w_addr_nxt  = {r_col, r_row};
                     w_wdata_nxt = i_cmd_data[15:0];
                  end
                  4'h9, 4'hA, 4'hB, 4'hD: begin
                     w_state_nxt = S_RD;
                     w_addr_nxt  = {r_col, r_row};
                  end
                  4'hC: begin
                     if (i_cmd_data[16 +: FILL_CNT_W] != '0) begin
                        w_state_nxt = S_FILL;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {r_col, r_row};
                        w_wdata_nxt = i_cmd_data[15:0];
                        w_cnt_nxt   = i_cmd_data[16 +: FILL_CNT_W] - FILL_CNT_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_CFG: w_state_nxt = S_IDLE;
         S_WRF: begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = w_adv_row;
            w_col_nxt   = w_adv_col;
         end
         S_RD: begin
            if (r_op == 4'hD) begin
               w_state_nxt    = S_RBK;
               w_rd_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = S_MOD;
               w_we_nxt    = 1'b1;
            end
         end
         S_MOD: begin
            w_state_nxt = S_IDLE;
            w_wdata_nxt = w_merge;
            w_row_nxt   = w_adv_row;
            w_col_nxt   = w_adv_col;
         end
         S_FILL: begin
            w_row_nxt = w_adv_row;
            w_col_nxt = w_adv_col;
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_we_nxt   = 1'b1;
               w_addr_nxt = {w_adv_col, w_adv_row};
               w_cnt_nxt  = r_cnt - FILL_CNT_W'(1);
            end
         end
         S_RBK: begin
            w_state_nxt   = S_IDLE;
            w_rd_data_nxt = i_ram_rdata;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_ready_nxt = (w_state_nxt == S_IDLE);

   assign o_cmd_ready  = r_ready;
   assign o_cfg_valid  = r_cfg_valid;
   assign o_cfg_data   = r_cfg_data;
   assign o_ram_addr   = r_addr;
   assign o_ram_we     = r_we;
   assign o_ram_wdata  = (r_state == S_MOD) ? w_merge : r_wdata;
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_data    = (r_state == S_RBK) ? i_ram_rdata : r_rd_data;
   assign o_cursor_row = r_row;
   assign o_cursor_col = r_col;

endmodule

// File: tb/tb_text_cmd_sequencer.sv
// Directed bench for text_cmd_sequencer: command table with expected bus/cursor
// results, a behavioural sync cell RAM, and hand-written reset/readback sequences.
module tb_text_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        cmd_ready;
   logic        cfg_valid;
   logic [31:0] cfg_data;
   logic [12:0] ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic [5:0]  cur_row;
   logic [6:0]  cur_col;

   logic [15:0] mem [0:8191];

   int n_vec = 0;
   int n_err = 0;

   text_cmd_sequencer dut (
      .i_cmd_clk   (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .i_cmd_data  (cmd_data),
      .o_cmd_ready (cmd_ready),
      .o_cfg_valid (cfg_valid),
      .o_cfg_data  (cfg_data),
      .o_ram_addr  (ram_addr),
      .o_ram_we    (ram_we),
      .o_ram_wdata (ram_wdata),
      .i_ram_rdata (ram_rdata),
      .o_rd_valid  (rd_valid),
      .o_rd_data   (rd_data),
      .o_cursor_row(cur_row),
      .o_cursor_col(cur_col)
   );

   always #5 clk = ~clk;

   // Synchronous cell RAM, read-before-write
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      logic [31:0] cmd;
      bit          pre_en;
      logic [12:0] pre_addr;
      logic [15:0] pre_data;
      int          busy;
      bit          ram;
      logic        first_we;
      logic [12:0] first_addr;
      int          writes;
      logic [12:0] last_addr;
      logic [15:0] last_data;
      bit          cfg;
      bit          rd;
      logic [15:0] rd_val;
      logic [5:0]  row;
      logic [6:0]  col;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [31:0] cmd, input bit pre_en,
                               input logic [12:0] pre_addr, input logic [15:0] pre_data,
                               input int busy, input bit ram, input logic first_we,
                               input logic [12:0] first_addr, input int writes,
                               input logic [12:0] last_addr, input logic [15:0] last_data,
                               input bit cfg, input bit rd, input logic [15:0] rd_val,
                               input logic [5:0] row, input logic [6:0] col);
      vec_t v;
      v.cmd = cmd; v.pre_en = pre_en; v.pre_addr = pre_addr; v.pre_data = pre_data;
      v.busy = busy; v.ram = ram; v.first_we = first_we; v.first_addr = first_addr;
      v.writes = writes; v.last_addr = last_addr; v.last_data = last_data;
      v.cfg = cfg; v.rd = rd; v.rd_val = rd_val; v.row = row; v.col = col;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int busy = 0, writes = 0, cfgs = 0, rds = 0;
      bit done = 0;
      logic        f_we = 1'b0;
      logic [12:0] f_addr = '0, l_addr = '0;
      logic [15:0] l_data = '0, r_val = '0;
      logic [31:0] c_val = '0;
      if (v.pre_en) mem[v.pre_addr] = v.pre_data;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = v.cmd;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            f_we      = ram_we;
            f_addr    = ram_addr;
            cmd_valid = 1'b0;
            cmd_data  = 32'h8000_FFFF;
         end
         if (ram_we) begin
            writes++;
            l_addr = ram_addr;
            l_data = ram_wdata;
         end
         if (cfg_valid) begin
            cfgs++;
            c_val = cfg_data;
         end
         if (rd_valid) begin
            rds++;
            r_val = rd_data;
         end
         if (cmd_ready) begin
            done = 1;
            break;
         end
         busy++;
      end
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'(v.busy));
      chk($sformatf("v%0d writes", idx), 32'(writes), 32'(v.writes));
      if (v.ram) begin
         chk($sformatf("v%0d first_we", idx), 32'(f_we), 32'(v.first_we));
         chk($sformatf("v%0d first_addr", idx), 32'(f_addr), 32'(v.first_addr));
      end
      if (v.writes > 0) begin
         chk($sformatf("v%0d last_addr", idx), 32'(l_addr), 32'(v.last_addr));
         chk($sformatf("v%0d last_wdata", idx), 32'(l_data), 32'(v.last_data));
      end
      chk($sformatf("v%0d cfg_strobes", idx), 32'(cfgs), 32'(v.cfg));
      if (v.cfg) chk($sformatf("v%0d cfg_data", idx), c_val, v.cmd);
      chk($sformatf("v%0d rd_strobes", idx), 32'(rds), 32'(v.rd));
      if (v.rd) chk($sformatf("v%0d rd_data", idx), 32'(r_val), 32'(v.rd_val));
      chk($sformatf("v%0d row", idx), 32'(cur_row), 32'(v.row));
      chk($sformatf("v%0d col", idx), 32'(cur_col), 32'(v.col));
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;

      //              cmd          pre  paddr    pdata     busy ram fwe faddr    wr laddr    ldata     cfg rd rdval     row    col
      vt.push_back(mk(32'h7005_0002, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd2,  7'd5));
      vt.push_back(mk(32'h8000_F141, 0, 13'h0,   16'h0,    1, 1, 1, 13'h0142, 1, 13'h0142, 16'hF141, 0, 0, 16'h0,    6'd2,  7'd6));
      vt.push_back(mk(32'h7005_0002, 1, 13'h142, 16'h1234, 0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd2,  7'd5));
      vt.push_back(mk(32'hA000_0009, 0, 13'h0,   16'h0,    2, 1, 0, 13'h0142, 1, 13'h0142, 16'h1934, 0, 0, 16'h0,    6'd2,  7'd6));
      vt.push_back(mk(32'h9000_0007, 1, 13'h182, 16'hABCD, 2, 1, 0, 13'h0182, 1, 13'h0182, 16'h7BCD, 0, 0, 16'h0,    6'd2,  7'd7));
      vt.push_back(mk(32'hB000_0055, 1, 13'h1C2, 16'h1234, 2, 1, 0, 13'h01C2, 1, 13'h01C2, 16'h1255, 0, 0, 16'h0,    6'd2,  7'd8));
      vt.push_back(mk(32'hD000_0000, 1, 13'h202, 16'hBEEF, 2, 1, 0, 13'h0202, 0, 13'h0,    16'h0,    0, 1, 16'hBEEF, 6'd2,  7'd8));
      vt.push_back(mk(32'h4000_3F00, 0, 13'h0,   16'h0,    1, 0, 0, 13'h0,    0, 13'h0,    16'h0,    1, 0, 16'h0,    6'd2,  7'd8));
      vt.push_back(mk(32'h7064_0003, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd3,  7'd83));
      vt.push_back(mk(32'h707F_0010, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd16, 7'd83));
      vt.push_back(mk(32'h7053_003F, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd63, 7'd83));
      vt.push_back(mk(32'h8000_0001, 0, 13'h0,   16'h0,    1, 1, 1, 13'h14FF, 1, 13'h14FF, 16'h0001, 0, 0, 16'h0,    6'd0,  7'd0));
      vt.push_back(mk(32'hC000_1111, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd0,  7'd0));
      vt.push_back(mk(32'h0000_0000, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd0,  7'd0));
      vt.push_back(mk(32'hF123_4567, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd0,  7'd0));
      vt.push_back(mk(32'h7052_003F, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd63, 7'd82));
      vt.push_back(mk(32'hC003_0720, 0, 13'h0,   16'h0,    3, 1, 1, 13'h14BF, 3, 13'h0000, 16'h0720, 0, 0, 16'h0,    6'd0,  7'd1));
      vt.push_back(mk(32'h1000_0001, 0, 13'h0,   16'h0,    1, 0, 0, 13'h0,    0, 13'h0,    16'h0,    1, 0, 16'h0,    6'd0,  7'd1));
      vt.push_back(mk(32'h6ABC_DEF0, 0, 13'h0,   16'h0,    1, 0, 0, 13'h0,    0, 13'h0,    16'h0,    1, 0, 16'h0,    6'd0,  7'd1));
      vt.push_back(mk(32'hE000_0000, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd0,  7'd1));
      vt.push_back(mk(32'h7052_003F, 0, 13'h0,   16'h0,    0, 0, 0, 13'h0,    0, 13'h0,    16'h0,    0, 0, 16'h0,    6'd63, 7'd82));
      vt.push_back(mk(32'hD000_0000, 0, 13'h0,   16'h0,    2, 1, 0, 13'h14BF, 0, 13'h0,    16'h0,    0, 1, 16'h0720, 6'd63, 7'd82));

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst ready", 32'(cmd_ready), 32'd1);
      chk("rst we", 32'(ram_we), 32'd0);
      chk("rst addr", 32'(ram_addr), 32'd0);
      chk("rst wdata", 32'(ram_wdata), 32'd0);
      chk("rst cfg_valid", 32'(cfg_valid), 32'd0);
      chk("rst cfg_data", cfg_data, 32'd0);
      chk("rst rd_valid", 32'(rd_valid), 32'd0);
      chk("rst rd_data", 32'(rd_data), 32'd0);
      chk("rst row", 32'(cur_row), 32'd0);
      chk("rst col", 32'(cur_col), 32'd0);

      foreach (vt[i]) run_vec(vt[i], i);

      // Readback value must persist after its strobe
      repeat (3) @(negedge clk);
      chk("rd_data held", 32'(rd_data), 32'h0720);
      chk("rd_valid low", 32'(rd_valid), 32'd0);

      // Reset in the middle of a fill
      run_vec(mk(32'h7052_003F, 0, 13'h0, 16'h0, 0, 0, 0, 13'h0, 0, 13'h0, 16'h0, 0, 0, 16'h0, 6'd63, 7'd82), 100);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = 32'hC003_0BAD;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("fill we k+1", 32'(ram_we), 32'd1);
      chk("fill addr k+1", 32'(ram_addr), 32'h14BF);
      #2 rst_n = 1'b0;
      #1;
      chk("abort we", 32'(ram_we), 32'd0);
      chk("abort row", 32'(cur_row), 32'd0);
      chk("abort col", 32'(cur_col), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post ready", 32'(cmd_ready), 32'd1);
      chk("post we", 32'(ram_we), 32'd0);
      chk("post rd_data", 32'(rd_data), 32'd0);
      chk("no write 14BF", 32'(mem[13'h14BF]), 32'h0720);
      chk("no write 14FF", 32'(mem[13'h14FF]), 32'h0720);
      run_vec(mk(32'hD000_0000, 0, 13'h0, 16'h0, 2, 1, 0, 13'h0000, 0, 13'h0, 16'h0, 0, 1, 16'h0720, 6'd0, 7'd0), 101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
